// File: rtl/itlb_ctrl.sv
// ---------------------------------------------------------------------------
// itlb_ctrl
//   Lookup/refill controller for the ITLB entry array. Keeps the VPN tags and
//   valid bits, matches fetch requests against them, and drives the entry
//   array's one-hot read enables on a hit. On a miss it runs a single
//   outstanding page-table walk and writes the returned PTE into a victim
//   entry. A flush invalidates every entry.
//
// Ports
//   clk_i, rstn_i            clock, synchronous active-low reset
//   req_*                    fetch translation request (valid/ready) + VPN
//   resp_*                   one-cycle response pulse: pte, hit, fault, replay
//   flush_i                  invalidate all entries
//   ptw_req_* / ptw_vpn_o    walk request handshake towards the PTW
//   ptw_resp_* / ptw_pte_i   walk result (one-cycle pulse) and fault flag
//   entry_rd_en_o            one-hot read enables to the entry array
//   entry_rd_pte_i           OR-reduced read data from the entry array
//   entry_we_o/entry_wdata_o one-hot write enables and refill data
// ---------------------------------------------------------------------------
`ifndef MXLEN
`define MXLEN 64
`endif

module itlb_ctrl #(
    parameter int ENTRIES = 8,
    parameter int VPN_W   = 27,
    parameter int PTE_W   = `MXLEN
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [VPN_W-1:0]   req_vpn_i,
    output logic               resp_valid_o,
    output logic [PTE_W-1:0]   resp_pte_o,
    output logic               resp_hit_o,
    output logic               resp_fault_o,
    output logic               resp_replay_o,
    input  logic               flush_i,
    output logic               ptw_req_valid_o,
    input  logic               ptw_req_ready_i,
    output logic [VPN_W-1:0]   ptw_vpn_o,
    input  logic               ptw_resp_valid_i,
    input  logic [PTE_W-1:0]   ptw_pte_i,
    input  logic               ptw_fault_i,
    output logic [ENTRIES-1:0] entry_rd_en_o,
    input  logic [PTE_W-1:0]   entry_rd_pte_i,
    output logic [ENTRIES-1:0] entry_we_o,
    output logic [PTE_W-1:0]   entry_wdata_o
);

    localparam int IDX_W = $clog2(ENTRIES);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WALK_REQ, S_WALK_WAIT, S_REFILL, S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [VPN_W-1:0]   tag_q [ENTRIES];
    logic [VPN_W-1:0]   tag_d [ENTRIES];
    logic [VPN_W-1:0]   vpn_q, vpn_d;
    logic [ENTRIES-1:0] hit_q, hit_d;
    logic [PTE_W-1:0]   pte_q, pte_d;
    logic [IDX_W-1:0]   victim_q, victim_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic               flush_pend_q, flush_pend_d;
    logic               fault_q, fault_d;
    logic               replay_q, replay_d;
    logic               refilled_q, refilled_d;

    logic [ENTRIES-1:0] hit_c;
    logic [IDX_W-1:0]   victim_c;
    logic               discard_c;

    function automatic logic [ENTRIES-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    // Tag match of the incoming request and victim choice: lowest-index
    // invalid entry, falling back to the round-robin pointer when full.
    always_comb begin
        hit_c    = '0;
        victim_c = rr_q;
        for (int i = 0; i < ENTRIES; i++) begin
            hit_c[i] = valid_q[i] && (tag_q[i] == req_vpn_i);
        end
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) victim_c = IDX_W'(i);
        end
    end

    // A flush seen at any point of the walk turns its result into a replay.
    assign discard_c = flush_pend_q | flush_i;

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        tag_d        = tag_q;
        vpn_d        = vpn_q;
        hit_d        = hit_q;
        pte_d        = pte_q;
        victim_d     = victim_q;
        rr_d         = rr_q;
        flush_pend_d = flush_pend_q;
        fault_d      = fault_q;
        replay_d     = replay_q;
        refilled_d   = refilled_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i && !flush_i) begin
                    vpn_d   = req_vpn_i;
                    hit_d   = hit_c;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                state_d = (|hit_q) ? S_IDLE : S_WALK_REQ;
            end
            S_WALK_REQ: begin
                if (flush_i) flush_pend_d = 1'b1;
                if (ptw_req_ready_i) state_d = S_WALK_WAIT;
            end
            S_WALK_WAIT: begin
                if (flush_i) flush_pend_d = 1'b1;
                if (ptw_resp_valid_i) begin
                    if (ptw_fault_i || discard_c) begin
                        fault_d    = ptw_fault_i;
                        replay_d   = discard_c;
                        refilled_d = 1'b0;
                        state_d    = S_RESP;
                    end else begin
                        pte_d   = ptw_pte_i;
                        state_d = S_REFILL;
                    end
                end
            end
            S_REFILL: begin
                // The entry is written even when a flush is pending; its valid
                // bit is then dropped by the flush override below.
                victim_d         = victim_c;
                tag_d[victim_c]  = vpn_q;
                valid_d[victim_c] = 1'b1;
                if (&valid_q) rr_d = rr_q + IDX_W'(1);
                fault_d    = 1'b0;
                replay_d   = discard_c;
                refilled_d = ~discard_c;
                state_d    = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_IDLE) flush_pend_d = 1'b0;
        if (flush_i) valid_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            vpn_q        <= '0;
            hit_q        <= '0;
            pte_q        <= '0;
            victim_q     <= '0;
            rr_q         <= '0;
            flush_pend_q <= 1'b0;
            fault_q      <= 1'b0;
            replay_q     <= 1'b0;
            refilled_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            vpn_q        <= vpn_d;
            hit_q        <= hit_d;
            pte_q        <= pte_d;
            victim_q     <= victim_d;
            rr_q         <= rr_d;
            flush_pend_q <= flush_pend_d;
            fault_q      <= fault_d;
            replay_q     <= replay_d;
            refilled_q   <= refilled_d;
        end
    end

    // Tags carry no reset: an entry's tag is only meaningful while valid.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i] <= tag_d[i];
        end
    end

    // Outputs decode the registered state; everything is forced to zero
    // while reset is held.
    always_comb begin
        logic lookup_hit;
        logic resp_st;
        logic rd_data;

        lookup_hit = rstn_i && (state_q == S_LOOKUP) && (|hit_q);
        resp_st    = rstn_i && (state_q == S_RESP);
        rd_data    = lookup_hit || (resp_st && refilled_q);

        req_ready_o     = rstn_i && (state_q == S_IDLE) && !flush_i;
        resp_valid_o    = lookup_hit || resp_st;
        resp_hit_o      = lookup_hit;
        resp_fault_o    = resp_st && fault_q;
        resp_replay_o   = resp_st && replay_q;
        resp_pte_o      = rd_data ? entry_rd_pte_i : '0;

        entry_rd_en_o   = '0;
        if (lookup_hit) entry_rd_en_o = hit_q;
        else if (resp_st && refilled_q) entry_rd_en_o = onehot(victim_q);

        ptw_req_valid_o = rstn_i && (state_q == S_WALK_REQ);
        ptw_vpn_o       = ptw_req_valid_o ? vpn_q : '0;

        entry_we_o      = '0;
        entry_wdata_o   = '0;
        if (rstn_i && (state_q == S_REFILL)) begin
            entry_we_o    = onehot(victim_c);
            entry_wdata_o = pte_q;
        end
    end

    a_rd_onehot: assert property (@(posedge clk_i) disable iff (!rstn_i)
        $onehot0(entry_rd_en_o));
    a_we_onehot: assert property (@(posedge clk_i) disable iff (!rstn_i)
        $onehot0(entry_we_o));
    a_single_hit: assert property (@(posedge clk_i) disable iff (!rstn_i)
        $onehot0(hit_c));
    a_resp_pulse: assert property (@(posedge clk_i) disable iff (!rstn_i)
        resp_valid_o |=> !resp_valid_o);

endmodule

// File: tb/tb_itlb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_itlb_ctrl
//   Self-checking bench for itlb_ctrl. Contains a behavioural entry array and
//   a PTW responder with a configurable delay. Expected responses are queued
//   when a request is driven and checked by a monitor when resp_valid_o fires.
// ---------------------------------------------------------------------------
module tb_itlb_ctrl;

    localparam int ENTRIES = 8;
    localparam int VPN_W   = 27;
    localparam int PTE_W   = 64;

    typedef struct {
        logic               hit;
        logic [PTE_W-1:0]   pte;
        logic               fault;
        logic               replay;
        logic [ENTRIES-1:0] rd_en;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rstn_i = 1'b0;
    logic               req_valid_i = 1'b0;
    logic               req_ready_o;
    logic [VPN_W-1:0]   req_vpn_i = '0;
    logic               resp_valid_o;
    logic [PTE_W-1:0]   resp_pte_o;
    logic               resp_hit_o;
    logic               resp_fault_o;
    logic               resp_replay_o;
    logic               flush_i = 1'b0;
    logic               ptw_req_valid_o;
    logic               ptw_req_ready_i = 1'b0;
    logic [VPN_W-1:0]   ptw_vpn_o;
    logic               ptw_resp_valid_i = 1'b0;
    logic [PTE_W-1:0]   ptw_pte_i = '0;
    logic               ptw_fault_i = 1'b0;
    logic [ENTRIES-1:0] entry_rd_en_o;
    logic [PTE_W-1:0]   entry_rd_pte_i;
    logic [ENTRIES-1:0] entry_we_o;
    logic [PTE_W-1:0]   entry_wdata_o;

    itlb_ctrl #(.ENTRIES(ENTRIES), .VPN_W(VPN_W), .PTE_W(PTE_W)) dut (
        .clk_i(clk), .rstn_i(rstn_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_vpn_i(req_vpn_i),
        .resp_valid_o(resp_valid_o), .resp_pte_o(resp_pte_o), .resp_hit_o(resp_hit_o),
        .resp_fault_o(resp_fault_o), .resp_replay_o(resp_replay_o),
        .flush_i(flush_i),
        .ptw_req_valid_o(ptw_req_valid_o), .ptw_req_ready_i(ptw_req_ready_i),
        .ptw_vpn_o(ptw_vpn_o), .ptw_resp_valid_i(ptw_resp_valid_i),
        .ptw_pte_i(ptw_pte_i), .ptw_fault_i(ptw_fault_i),
        .entry_rd_en_o(entry_rd_en_o), .entry_rd_pte_i(entry_rd_pte_i),
        .entry_we_o(entry_we_o), .entry_wdata_o(entry_wdata_o)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int resp_seen = 0;
    int resp_cyc  = 0;
    exp_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Entry array: written by entry_we_o, read data OR-reduced over enables.
    logic [PTE_W-1:0]   ent_mem [ENTRIES];
    int                 we_count = 0;
    logic [ENTRIES-1:0] last_we  = '0;

    always @(posedge clk) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (entry_we_o[i]) ent_mem[i] <= entry_wdata_o;
        end
        if (entry_we_o != '0) begin
            we_count <= we_count + 1;
            last_we  <= entry_we_o;
        end
    end

    always_comb begin
        entry_rd_pte_i = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (entry_rd_en_o[i]) entry_rd_pte_i = entry_rd_pte_i | ent_mem[i];
        end
    end

    // PTW responder: accepts a walk, then returns the configured result
    // ptw_delay_cfg cycles after the handshake edge.
    int               ptw_delay_cfg = 3;
    logic [PTE_W-1:0] ptw_pte_cfg   = '0;
    logic             ptw_fault_cfg = 1'b0;
    logic             ptw_hs        = 1'b0;
    bit               ptw_pending   = 1'b0;
    int               ptw_cnt       = 0;

    always @(posedge clk) ptw_hs <= ptw_req_valid_o && ptw_req_ready_i;

    initial begin
        forever begin
            @(negedge clk);
            ptw_resp_valid_i = 1'b0;
            ptw_fault_i      = 1'b0;
            ptw_pte_i        = '0;
            if (!rstn_i) begin
                ptw_pending     = 1'b0;
                ptw_req_ready_i = 1'b0;
            end else begin
                if (ptw_hs) begin
                    ptw_pending = 1'b1;
                    ptw_cnt     = ptw_delay_cfg;
                end
                if (ptw_pending) begin
                    ptw_cnt--;
                    if (ptw_cnt == 0) begin
                        ptw_resp_valid_i = 1'b1;
                        ptw_pte_i        = ptw_pte_cfg;
                        ptw_fault_i      = ptw_fault_cfg;
                        ptw_pending      = 1'b0;
                    end
                end
                ptw_req_ready_i = ptw_req_valid_o && !ptw_pending && !ptw_hs;
            end
        end
    end

    // Scoreboard monitor: every response pops one expected entry.
    logic prev_resp = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (resp_valid_o) begin
            resp_seen++;
            resp_cyc = cyc;
            n_checks++;
            if (prev_resp) begin
                n_fail++;
                $display("[TB] FAIL resp_pulse: resp_valid high in consecutive cycles (got 1, need 0)");
            end
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL unexpected_resp: got a response, none expected");
            end else begin
                e = exp_q.pop_front();
                n_checks += 5;
                if (resp_hit_o !== e.hit) begin
                    n_fail++; $display("[TB] FAIL resp_hit: got %0b need %0b", resp_hit_o, e.hit);
                end
                if (resp_pte_o !== e.pte) begin
                    n_fail++; $display("[TB] FAIL resp_pte: got %h need %h", resp_pte_o, e.pte);
                end
                if (resp_fault_o !== e.fault) begin
                    n_fail++; $display("[TB] FAIL resp_fault: got %0b need %0b", resp_fault_o, e.fault);
                end
                if (resp_replay_o !== e.replay) begin
                    n_fail++; $display("[TB] FAIL resp_replay: got %0b need %0b", resp_replay_o, e.replay);
                end
                if (entry_rd_en_o !== e.rd_en) begin
                    n_fail++; $display("[TB] FAIL resp_rd_en: got %h need %h", entry_rd_en_o, e.rd_en);
                end
            end
        end
        prev_resp = resp_valid_o;
    end

    function automatic exp_t mk_exp(input logic hit, input logic [PTE_W-1:0] pte,
                                    input logic fault, input logic replay,
                                    input logic [ENTRIES-1:0] rd_en);
        exp_t e;
        e.hit = hit; e.pte = pte; e.fault = fault; e.replay = replay; e.rd_en = rd_en;
        return e;
    endfunction

    // Drives one request, waits (bounded) for acceptance and the response.
    // lat = 1 means the response came in the cycle right after acceptance.
    task automatic send_req(input logic [VPN_W-1:0] vpn, input exp_t e, output int lat);
        int  start;
        int  acc;
        bit  done;
        exp_q.push_back(e);
        start = resp_seen;
        lat   = -1;
        @(negedge clk);
        req_valid_i = 1'b1;
        req_vpn_i   = vpn;
        done = 1'b0;
        for (int k = 0; k < 50; k++) begin
            #1;
            if (req_ready_o) begin done = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++;
        if (!done) begin
            n_fail++; $display("[TB] FAIL accept_timeout: vpn %h not accepted", vpn);
        end
        @(posedge clk);
        #1;
        acc = cyc;
        req_valid_i = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            #1;
            if (resp_seen != start) begin done = 1'b1; break; end
        end
        n_checks++;
        if (!done) begin
            n_fail++; $display("[TB] FAIL resp_timeout: no response for vpn %h", vpn);
        end else begin
            lat = resp_cyc - acc + 1;
        end
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        req_valid_i = 1'b1;
        req_vpn_i = 27'h123;
        repeat (2) @(negedge clk);
        #1;
        n_checks += 5;
        if (req_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_ready: got %0b need 0", req_ready_o); end
        if (resp_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_resp: got %0b need 0", resp_valid_o); end
        if (ptw_req_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_ptw: got %0b need 0", ptw_req_valid_o); end
        if (entry_we_o !== '0) begin n_fail++; $display("[TB] FAIL rst_we: got %h need 0", entry_we_o); end
        if (entry_rd_en_o !== '0) begin n_fail++; $display("[TB] FAIL rst_rd_en: got %h need 0", entry_rd_en_o); end
        req_valid_i = 1'b0;
        @(negedge clk);
        rstn_i = 1'b1;
        #1;
        n_checks++;
        if (req_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL idle_ready: got %0b need 1", req_ready_o); end
    endtask

    task automatic test_miss_then_hit();
        int lat;
        int w0;
        ptw_delay_cfg = 3; ptw_pte_cfg = 64'hAA01; ptw_fault_cfg = 1'b0;
        w0 = we_count;
        send_req(27'h123, mk_exp(1'b0, 64'hAA01, 1'b0, 1'b0, 8'h01), lat);
        n_checks += 3;
        if (we_count != w0 + 1) begin n_fail++; $display("[TB] FAIL refill_count: got %0d need %0d", we_count - w0, 1); end
        if (last_we !== 8'h01) begin n_fail++; $display("[TB] FAIL refill_we: got %h need 01", last_we); end
        if (lat != 7) begin n_fail++; $display("[TB] FAIL miss_latency: got %0d need 7", lat); end
        w0 = we_count;
        send_req(27'h123, mk_exp(1'b1, 64'hAA01, 1'b0, 1'b0, 8'h01), lat);
        n_checks += 2;
        if (lat != 1) begin n_fail++; $display("[TB] FAIL hit_latency: got %0d need 1", lat); end
        if (we_count != w0) begin n_fail++; $display("[TB] FAIL hit_no_write: got %0d writes need 0", we_count - w0); end
    endtask

    task automatic test_replacement();
        int lat;
        ptw_delay_cfg = 2;
        for (int i = 1; i < ENTRIES; i++) begin
            ptw_pte_cfg = 64'hB000 + 64'(i);
            send_req(27'h200 + 27'(i), mk_exp(1'b0, 64'hB000 + 64'(i), 1'b0, 1'b0, 8'(1 << i)), lat);
            n_checks++;
            if (last_we !== 8'(1 << i)) begin n_fail++; $display("[TB] FAIL fill_we_%0d: got %h need %h", i, last_we, 8'(1 << i)); end
        end
        ptw_pte_cfg = 64'hB100;
        send_req(27'h300, mk_exp(1'b0, 64'hB100, 1'b0, 1'b0, 8'h01), lat);
        n_checks++;
        if (last_we !== 8'h01) begin n_fail++; $display("[TB] FAIL rr_victim0: got %h need 01", last_we); end
        ptw_pte_cfg = 64'hB101;
        send_req(27'h301, mk_exp(1'b0, 64'hB101, 1'b0, 1'b0, 8'h02), lat);
        n_checks++;
        if (last_we !== 8'h02) begin n_fail++; $display("[TB] FAIL rr_victim1: got %h need 02", last_we); end
        send_req(27'h203, mk_exp(1'b1, 64'hB003, 1'b0, 1'b0, 8'h08), lat);
        ptw_pte_cfg = 64'hAA02;
        send_req(27'h123, mk_exp(1'b0, 64'hAA02, 1'b0, 1'b0, 8'h04), lat);
        n_checks++;
        if (last_we !== 8'h04) begin n_fail++; $display("[TB] FAIL evicted_refill: got %h need 04", last_we); end
    endtask

    task automatic test_fault();
        int lat;
        int w0;
        w0 = we_count;
        ptw_fault_cfg = 1'b1; ptw_pte_cfg = 64'hDEAD;
        send_req(27'h400, mk_exp(1'b0, 64'h0, 1'b1, 1'b0, 8'h00), lat);
        n_checks++;
        if (we_count != w0) begin n_fail++; $display("[TB] FAIL fault_no_write: got %0d writes need 0", we_count - w0); end
        ptw_fault_cfg = 1'b0; ptw_pte_cfg = 64'hC400;
        send_req(27'h400, mk_exp(1'b0, 64'hC400, 1'b0, 1'b0, 8'h08), lat);
        n_checks++;
        if (last_we !== 8'h08) begin n_fail++; $display("[TB] FAIL fault_rewalk_we: got %h need 08", last_we); end
    endtask

    task automatic test_flush_walk();
        int lat;
        int w0;
        w0 = we_count;
        ptw_delay_cfg = 5; ptw_pte_cfg = 64'hC500;
        fork
            send_req(27'h500, mk_exp(1'b0, 64'h0, 1'b0, 1'b1, 8'h00), lat);
            begin
                bit seen;
                seen = 1'b0;
                for (int k = 0; k < 100; k++) begin
                    @(negedge clk);
                    if (ptw_hs) begin seen = 1'b1; break; end
                end
                n_checks++;
                if (!seen) begin n_fail++; $display("[TB] FAIL flush_window: walk handshake not seen"); end
                flush_i = 1'b1;
                @(negedge clk);
                flush_i = 1'b0;
            end
        join
        n_checks++;
        if (we_count != w0) begin n_fail++; $display("[TB] FAIL flush_no_write: got %0d writes need 0", we_count - w0); end
        ptw_delay_cfg = 2; ptw_pte_cfg = 64'hC501;
        send_req(27'h500, mk_exp(1'b0, 64'hC501, 1'b0, 1'b0, 8'h01), lat);
        ptw_pte_cfg = 64'hC203;
        send_req(27'h203, mk_exp(1'b0, 64'hC203, 1'b0, 1'b0, 8'h02), lat);
        n_checks++;
        if (last_we !== 8'h02) begin n_fail++; $display("[TB] FAIL post_flush_we: got %h need 02", last_we); end
    endtask

    task automatic test_flush_idle();
        int  start;
        bit  done;
        ptw_pte_cfg = 64'hD500;
        exp_q.push_back(mk_exp(1'b0, 64'hD500, 1'b0, 1'b0, 8'h01));
        start = resp_seen;
        @(negedge clk);
        flush_i = 1'b1; req_valid_i = 1'b1; req_vpn_i = 27'h500;
        #1;
        n_checks++;
        if (req_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_ready: got %0b need 0", req_ready_o); end
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        n_checks++;
        if (req_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_next_ready: got %0b need 1", req_ready_o); end
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            #1;
            if (resp_seen != start) begin done = 1'b1; break; end
        end
        n_checks += 2;
        if (!done) begin n_fail++; $display("[TB] FAIL flush_idle_timeout: no response"); end
        if (last_we !== 8'h01) begin n_fail++; $display("[TB] FAIL flush_idle_we: got %h need 01", last_we); end
    endtask

    task automatic test_reset_walk();
        int  lat;
        int  start;
        bit  seen;
        ptw_pte_cfg = 64'hE600;
        send_req(27'h600, mk_exp(1'b0, 64'hE600, 1'b0, 1'b0, 8'h02), lat);
        ptw_delay_cfg = 4; ptw_pte_cfg = 64'hE700;
        start = resp_seen;
        @(negedge clk);
        req_valid_i = 1'b1; req_vpn_i = 27'h700;
        #1;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            if (ptw_req_valid_o) begin seen = 1'b1; break; end
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("[TB] FAIL walk_req_seen: ptw_req_valid never rose"); end
        rstn_i = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (ptw_req_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_walk_ptw: got %0b need 0", ptw_req_valid_o); end
        @(negedge clk);
        rstn_i = 1'b1;
        repeat (15) @(negedge clk);
        #1;
        n_checks++;
        if (resp_seen != start) begin n_fail++; $display("[TB] FAIL rst_walk_resp: got %0d responses need 0", resp_seen - start); end
        ptw_delay_cfg = 2;
        ptw_pte_cfg = 64'hF500;
        send_req(27'h500, mk_exp(1'b0, 64'hF500, 1'b0, 1'b0, 8'h01), lat);
        ptw_pte_cfg = 64'hF600;
        send_req(27'h600, mk_exp(1'b0, 64'hF600, 1'b0, 1'b0, 8'h02), lat);
    endtask

    task automatic test_back_to_back();
        int lat;
        send_req(27'h500, mk_exp(1'b1, 64'hF500, 1'b0, 1'b0, 8'h01), lat);
        n_checks++;
        if (lat != 1) begin n_fail++; $display("[TB] FAIL b2b_lat0: got %0d need 1", lat); end
        send_req(27'h600, mk_exp(1'b1, 64'hF600, 1'b0, 1'b0, 8'h02), lat);
        n_checks++;
        if (lat != 1) begin n_fail++; $display("[TB] FAIL b2b_lat1: got %0d need 1", lat); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_miss_then_hit();
        test_replacement();
        test_fault();
        test_flush_walk();
        test_flush_idle();
        test_reset_walk();
        test_back_to_back();
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("[TB] FAIL scoreboard_drain: got %0d pending need 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/itlb_ctrl.md
Name: itlb_ctrl

Overview:
- Lookup/refill controller for the ITLB entry array.
- Holds per-entry VPN tags and valid bits.
- Compares fetch requests against tags; on a hit, drives the entry array's one-hot read enables.
- On a miss, runs a single-outstanding page-table-walk handshake and writes the returned PTE into a victim entry. Also services flush (sfence.vma) requests.

Parameters:
- ENTRIES, 8, number of ITLB entries (power of 2, >=2).
- VPN_W, 27, virtual page number width (Sv39).
- PTE_W, `MXLEN, PTE width; matches the entry array data width.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset, synchronous, active-low.
- req_valid_i  in  1  fetch translation request.
- req_ready_o  out  1  request accepted when valid&ready.
- req_vpn_i  in  VPN_W  request VPN.
- resp_valid_o  out  1  single-cycle response pulse; no backpressure.
- resp_pte_o  out  PTE_W  translated PTE.
- resp_hit_o  out  1  1 = served from the TLB; 0 = served by a walk.
- resp_fault_o  out  1  walk reported a page fault.
- resp_replay_o  out  1  result discarded due to flush; fetch must retry.
- flush_i  in  1  invalidate all entries.
- ptw_req_valid_o  out  1  walk request.
- ptw_req_ready_i  in  1  PTW accepts the request.
- ptw_vpn_o  out  VPN_W  VPN to walk.
- ptw_resp_valid_i  in  1  walk result valid (one cycle).
- ptw_pte_i  in  PTE_W  walked PTE.
- ptw_fault_i  in  1  walk fault.
- entry_rd_en_o  out  ENTRIES  one-hot read enables to the entries.
- entry_rd_pte_i  in  PTE_W  OR-reduced entry read data (entries output 0 when not enabled).
- entry_we_o  out  ENTRIES  one-hot write enables.
- entry_wdata_o  out  PTE_W  refill data.

Behaviour:
- Reset (rstn_i low at a clk edge):
  - State IDLE; valid[] = 0; rr_ptr = 0; flush_pend = 0.
  - All outputs 0, including req_ready_o while rstn_i is low.
  - Reset mid-walk abandons the walk; no response is produced.
- FSM states: IDLE, LOOKUP, WALK_REQ, WALK_WAIT, REFILL, RESP.
- req_ready_o = (state==IDLE) & ~flush_i.
- IDLE: on accept, latch vpn, compute hit vector (valid[i] & tag[i]==vpn) into a register, go to LOOKUP.
- LOOKUP:
  - Hit: entry_rd_en_o = registered hit vector; resp_valid_o=1, resp_hit_o=1, resp_pte_o=entry_rd_pte_i; go to IDLE. Hit latency is 1 cycle after accept.
  - Miss: go to WALK_REQ; no response this cycle.
- WALK_REQ:
  - ptw_req_valid_o=1, ptw_vpn_o=latched vpn, both held stable until ptw_req_ready_i.
  - On handshake, go to WALK_WAIT. Same-cycle ptw_resp_valid_i is not legal.
- WALK_WAIT: on ptw_resp_valid_i:
  - Fault or flush_pend: go to RESP with resp_fault_o=ptw_fault_i, resp_replay_o=flush_pend, and no refill.
  - Otherwise latch the PTE and go to REFILL.
- REFILL:
  - Victim = lowest-index invalid entry; if all entries are valid, victim = rr_ptr, and rr_ptr increments mod ENTRIES (only when all are valid).
  - entry_we_o = onehot(victim), entry_wdata_o = PTE, tag[victim] = vpn, valid[victim] = 1. Go to RESP.
- RESP:
  - resp_valid_o=1, resp_hit_o=0.
  - After a refill: entry_rd_en_o = onehot(victim), resp_pte_o = entry_rd_pte_i.
  - After a fault or replay: entry_rd_en_o = 0, resp_pte_o = 0.
  - Go to IDLE.
- Miss-to-response latency: 2 (handshake/return) + PTW delay + 2 cycles.
- Flush:
  - flush_i clears every valid[] bit at the next edge and takes priority over a same-cycle refill set.
  - Flush in WALK_REQ or WALK_WAIT sets flush_pend. The walk handshake still completes; the result is discarded and the response carries replay=1.
  - Flush in REFILL: the write to the entry still happens, but valid stays 0 and the response carries replay=1.
  - Flush in LOOKUP on a hit: the hit response is still returned from data already read.
  - flush_pend clears on entry to IDLE.
- Outside LOOKUP/RESP: entry_rd_en_o = 0 and resp_* = 0.
- entry_we_o is nonzero only in REFILL.
- Invariants (assert):
  - $onehot0(entry_rd_en_o) and $onehot0(entry_we_o).
  - At most one tag hit (duplicates are impossible: refill only follows a miss and there is one outstanding request).
  - resp_valid_o is never asserted in consecutive cycles.

Test Plan:
1. Reset; request vpn 0x123; PTW returns pte 0xAA01 after 3 cycles, no fault -> entry_we_o=0x01, resp_valid with hit=0, pte=0xAA01; repeat request -> resp 1 cycle after accept, hit=1, entry_rd_en_o=0x01.
2. Fill 8 distinct VPNs, then miss on a 9th and a 10th -> victims entry 0 then entry 1 (rr_ptr 0→1→2); the original VPN of entry 0 now misses.
3. Miss with ptw_fault_i=1 -> resp fault=1, hit=0, pte=0; entry_we_o stays 0; the same VPN misses again.
4. flush_i during WALK_WAIT -> PTW response discarded, resp replay=1, no write; the next request for that VPN walks again.
5. flush_i asserted in the same cycle as req_valid_i in IDLE -> req_ready_o=0, all valid bits cleared; the request is accepted the next cycle and misses.
6. rstn_i low during WALK_REQ -> next cycle ptw_req_valid_o=0, resp_valid_o never pulses, all prior entries miss.
